// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: pipeline request/response channel and memory port.
// The unit connects through the slave modport; the master modport is the far side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
    input  mem_resp, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport master (
    output req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
    output mem_resp, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store unit: checks alignment and opcode, drives one memory strobe per request,
// lane-shifts store data, extends load data, and optionally times out a silent memory.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_read_q, is_read_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              f3_illegal;
  logic              misaligned;
  logic              req_err;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_data;
  logic [31:0]       store_wdata;
  logic [3:0]        store_be;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      is_read_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      is_read_q    <= is_read_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // Request decode on live inputs, lane handling on the latched request.
  always_comb begin
    f3_illegal = 1'b0;
    misaligned = 1'b0;
    if (bus.req_read) begin
      case (bus.req_funct3)
        3'b011, 3'b110, 3'b111: f3_illegal = 1'b1;
        default:                f3_illegal = 1'b0;
      endcase
    end else begin
      f3_illegal = (bus.req_funct3 > 3'b010);
    end
    case (bus.req_funct3[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    req_err = (bus.req_read == bus.req_write) || f3_illegal || misaligned;

    case (addr_q[1:0])
      2'b00:   load_byte = bus.mem_rdata[7:0];
      2'b01:   load_byte = bus.mem_rdata[15:8];
      2'b10:   load_byte = bus.mem_rdata[23:16];
      default: load_byte = bus.mem_rdata[31:24];
    endcase
    load_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = bus.mem_rdata;
    endcase

    case (funct3_q[1:0])
      2'b00: begin
        store_wdata = {4{wdata_q[7:0]}};
        store_be    = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        store_wdata = {2{wdata_q[15:0]}};
        store_be    = 4'b0011 << addr_q[1:0];
      end
      default: begin
        store_wdata = wdata_q;
        store_be    = 4'b1111;
      end
    endcase
  end

  // Next state; errors detected at accept skip the memory and report straight away.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    is_read_d    = is_read_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d    = bus.req_addr;
          funct3_d  = bus.req_funct3;
          wdata_d   = bus.req_wdata;
          is_read_d = bus.req_read;
          if (req_err) begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ACCESS: begin
        if (bus.mem_resp) begin
          state_d      = RESP;
          resp_err_d   = 1'b0;
          resp_rdata_d = is_read_q ? load_data : 32'h0;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT)) begin
          state_d      = RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready       = (state_q == IDLE);
    bus.resp_valid      = (state_q == RESP);
    bus.resp_err        = resp_err_q;
    bus.resp_rdata      = resp_rdata_q;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    if (state_q == ACCESS) begin
      bus.mem_read        = is_read_q;
      bus.mem_write       = !is_read_q;
      bus.mem_address     = {addr_q[31:2], 2'b00};
      bus.mem_wdata       = is_read_q ? 32'h0 : store_wdata;
      bus.mem_byte_enable = is_read_q ? 4'b1111 : store_be;
    end
  end

endmodule
